rs232_rx_deframer: RTL and testbench
====================================

# rs232_rx_deframer

RS232 receive deframer for the serial echo path. It sits directly upstream of the byte-processing/transmit stage. It samples the asynchronous `rx` line at 50 MHz, recovers 8-bit frames (start, 8 data LSB-first, optional parity, stop), and presents each byte on a valid/ready interface with per-byte error qualification. The default mode is 115200 baud, 1 stop bit, even parity, no flow control.

## Interface
- `CLK_FREQ`, 50000000: clock frequency in Hz.
- `BAUD`, 115200: line rate. `BIT_TICKS = CLK_FREQ/BAUD` (434), `HALF_TICKS = BIT_TICKS/2` (217), both integer-truncated.
- `PARITY`, 1: 0 = none, 1 = even, 2 = odd.
- `clk`, in, 1: system clock (50 MHz).
- `rst`, in, 1: synchronous, active-high reset.
- `rx`, in, 1: asynchronous serial input; idles high.
- `data_out`, out, 8: received byte.
- `data_valid`, out, 1: `data_out` and `parity_err` are valid; held until accepted.
- `data_ready`, in, 1: downstream accept. A transfer occurs when `data_valid` and `data_ready` are both high on a rising edge.
- `parity_err`, out, 1: qualifies the current `data_out`; high when the received parity mismatches.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, out, 1: one-cycle pulse when a completed byte is dropped because the output is occupied.
- `busy`, out, 1: high whenever the FSM is not in `IDLE`.

## Operation
- `rx` passes through a 2-flop synchronizer, with both flops reset to 1. `rxs` is the synchronized bit.
- FSM states: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`, `BREAK`. A single tick counter runs, reloaded on every state change.
- `IDLE`: when `rxs == 0`, go to `START` with the counter cleared.
- `START`: at count `HALF_TICKS-1`, sample `rxs`.
  - If 0, go to `DATA`.
  - If 1, treat it as a glitch and return to `IDLE`. Nothing is reported.
- `DATA`: sample every `BIT_TICKS` cycles and shift into bit [7] (LSB-first). After the 8th sample, go to `PARITY` when `PARITY != 0`, otherwise `STOP`.
- `PARITY`: sample after `BIT_TICKS`.
  - Even mode: `parity_err = ^data ^ sample`.
  - Odd mode: `parity_err` is the inverse of that.
  - Go to `STOP`.
- `STOP`: sample after `BIT_TICKS`.
  - Sample 1: complete the byte and go to `IDLE`.
  - Sample 0: pulse `frame_err`, drop the byte, go to `BREAK`.
- `BREAK`: wait for `rxs == 1`, then go to `IDLE`. A held-low line produces exactly one `frame_err`.
- Byte completion:
  - If the output is empty, or is being accepted this same cycle (`data_valid && data_ready`): load `data_out`/`parity_err` and set `data_valid`. No overrun.
  - Otherwise: keep the held byte, discard the new one, pulse `overrun`.
- `data_valid` clears on a transfer unless a new byte loads in the same cycle.
- With `PARITY == 0`, `parity_err` is always 0.

## Timing
- Reset (rst high at an edge) forces, on that edge:
  - FSM to `IDLE`, counter to 0, synchronizer to 1.
  - `data_out = 0`, `data_valid = 0`, `parity_err = 0`, `frame_err = 0`, `overrun = 0`, `busy = 0`.
  - Reset mid-frame abandons the frame silently.
- Input latency: 2 cycles, `rx` to `rxs`.
- Let t0 be the first cycle `rxs == 0` is seen in `IDLE`:
  - Start sample at t0+217.
  - Data bit k sample at t0+217+434·(k+1).
  - Parity sample at t0+4123.
  - Stop sample at t0+4557 with parity, or t0+4123 without.
- `data_valid`, `frame_err` and `overrun` register one cycle after the stop sample.
- Throughput: back-to-back frames are accepted. The FSM is in `IDLE` from the cycle after the stop sample, which is mid-stop-bit, so the next start edge is caught.
- `busy` is registered and follows the state with one cycle of lag at most.

## Structure
- Shared header `rs232_defs`:
  - FSM state encodings.
  - `PARITY_NONE/EVEN/ODD` constants.
  - `BIT_TICKS`/`HALF_TICKS` derivation, reused by the transmit stage.
- Sub-module `sync_2ff`: parameterised reset value and width, instantiated for `rx` and reusable for `rts`.
- The FSM, counter, shift register and output register stay in the top module.

## Test plan
Expected times are checked within ±2 cycles.
1. Frame 0x53 (bits 1,1,0,0,1,0,1,0; parity 0; stop 1) with `data_ready = 1`:
   - Response: `data_out = 0x53`, one-cycle `data_valid` at t0+4558.
   - `parity_err = 0`, no `frame_err` or `overrun`.
2. Frame 0x53 with parity bit 1:
   - Response: `data_out = 0x53` with `parity_err = 1` during `data_valid`.
3. Frame 0x53 with stop bit 0, `rx` held low 2000 cycles, then frame 0xA5 with correct parity:
   - One `frame_err` pulse and no `data_valid` for the first frame.
   - 0xA5 then delivered cleanly.
4. `rx` low for 100 cycles, then high:
   - No `data_valid` and no errors.
   - `busy` returns to 0 near t0+218.
5. `data_ready = 0`, frames 0x01 then 0x02:
   - `data_out` stays 0x01, with an `overrun` pulse at the second completion.
   - Raising `data_ready` gives one transfer of 0x01; 0x02 is never presented.
6. `rst` pulsed during `DATA` of frame 0x53:
   - All outputs 0 and `busy = 0` the following cycle.
   - A subsequent full 0x53 frame is delivered correctly.

Source files
------------

// File: rtl/rs232_rx_deframer_pkg.sv
// Shared RS232 definitions: FSM encodings, parity modes and bit-timing derivation
// used by both the receive deframer and the transmit stage.
package rs232_rx_deframer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int bit_ticks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_ticks(input int clk_freq, input int baud);
    return bit_ticks(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/rs232_rx_deframer_sync_2ff.sv
// Two-flop synchronizer with a parameterised reset value; latency 2 cycles, no backpressure.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rs232_rx_deframer.sv
// RS232 receive deframer: byte valid one cycle after the stop sample; output held until
// data_ready, a byte completing while the output is still occupied is dropped with overrun.
module rs232_rx_deframer #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int PARITY   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  import rs232_rx_deframer_pkg::*;

  localparam int BIT_TICKS  = bit_ticks(CLK_FREQ, BAUD);
  localparam int HALF_TICKS = half_ticks(CLK_FREQ, BAUD);
  localparam int CW         = $clog2(BIT_TICKS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_TICKS - 1);
  localparam logic PAR_ODD = (PARITY == PARITY_ODD);
  localparam logic PAR_EN  = (PARITY != PARITY_NONE);

  logic rxs;

  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rxs)
  );

  rx_state_t       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            perr, perr_nxt;
  logic            complete;
  logic            frame_err_nxt;
  logic [7:0]      data_out_nxt;
  logic            data_valid_nxt;
  logic            parity_err_nxt;
  logic            overrun_nxt;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + CW'(1);
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    perr_nxt      = perr;
    complete      = 1'b0;
    frame_err_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (!rxs) state_nxt = ST_START;
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt     = '0;
          bit_cnt_nxt = '0;
          state_nxt   = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rxs, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          perr_nxt  = (^shreg) ^ rxs ^ PAR_ODD;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rxs) begin
            complete  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Line held low after a bad stop bit: wait out the break before rearming.
        cnt_nxt = '0;
        if (rxs) state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    data_out_nxt   = data_out;
    data_valid_nxt = data_valid && !data_ready;
    parity_err_nxt = parity_err;
    overrun_nxt    = 1'b0;
    if (complete) begin
      if (!data_valid || data_ready) begin
        data_out_nxt   = shreg;
        data_valid_nxt = 1'b1;
        parity_err_nxt = PAR_EN ? perr : 1'b0;
      end else begin
        overrun_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      perr       <= perr_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      parity_err <= parity_err_nxt;
      frame_err  <= frame_err_nxt;
      overrun    <= overrun_nxt;
      busy       <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_rs232_rx_deframer.sv
// Bench for rs232_rx_deframer at 115200 baud, even parity.
module tb_rs232_rx_deframer;

  localparam int BT  = 434;
  localparam int LAT = 4560;  // rx start edge driven to data_valid visible (2 sync + t0+4558)

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  rs232_rx_deframer dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [8:0] got_q[$];
  int         got_cyc[$];
  int         dv_cnt, ferr_cnt, ovr_cnt, ovr_cyc;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) dv_cnt++;
      if (data_valid && data_ready) begin
        got_q.push_back({parity_err, data_out});
        got_cyc.push_back(cyc);
      end
      if (frame_err) ferr_cnt++;
      if (overrun) begin
        ovr_cnt++;
        ovr_cyc = cyc;
      end
    end
  end

  function automatic logic even_bit(input logic [7:0] b);
    return logic'($countones(b) % 2);
  endfunction

  task automatic clear_mon();
    got_q.delete();
    got_cyc.delete();
    dv_cnt   = 0;
    ferr_cnt = 0;
    ovr_cnt  = 0;
    ovr_cyc  = 0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pbit, input logic stopb,
                            output int start);
    @(posedge clk);
    #1;
    start = cyc;
    rx = 1'b0;
    hold(BT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(BT);
    end
    rx = pbit;
    hold(BT);
    rx = stopb;
    hold(BT);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    data_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold(20);
  endtask

  task automatic test_good_frame();
    logic [7:0] b = 8'h53;
    int s;
    clear_mon();
    data_ready = 1'b1;
    send_frame(b, even_bit(b), 1'b1, s);
    hold(100);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL good_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0][7:0] !== b) begin errors++; $display("FAIL good_data: got %h want %h", got_q[0][7:0], b); end
      checks++; if (got_q[0][8] !== 1'b0) begin errors++; $display("FAIL good_perr: got %b want 0", got_q[0][8]); end
      checks++;
      if (got_cyc[0] < s + LAT - 2 || got_cyc[0] > s + LAT + 2) begin
        errors++; $display("FAIL good_timing: got cycle %0d want %0d", got_cyc[0], s + LAT);
      end
    end
    checks++; if (dv_cnt != 1) begin errors++; $display("FAIL good_valid_width: got %0d want 1", dv_cnt); end
    checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL good_frame_err: got %0d want 0", ferr_cnt); end
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL good_overrun: got %0d want 0", ovr_cnt); end
  endtask

  task automatic test_parity_err();
    logic [7:0] b = 8'h53;
    int s;
    clear_mon();
    send_frame(b, ~even_bit(b), 1'b1, s);
    hold(100);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL perr_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== {1'b1, b}) begin errors++; $display("FAIL perr_word: got %h want %h", got_q[0], {1'b1, b}); end
    end
    checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL perr_frame_err: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_frame_err();
    logic [7:0] b1 = 8'h53;
    logic [7:0] b2 = 8'hA5;
    int s;
    clear_mon();
    send_frame(b1, even_bit(b1), 1'b0, s);
    hold(2000);
    rx = 1'b1;
    hold(300);
    checks++; if (dv_cnt != 0) begin errors++; $display("FAIL ferr_no_valid: got %0d want 0", dv_cnt); end
    send_frame(b2, even_bit(b2), 1'b1, s);
    hold(100);
    checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== {1'b0, b2}) begin errors++; $display("FAIL ferr_next_word: got %h want %h", got_q[0], {1'b0, b2}); end
    end
  endtask

  task automatic test_glitch();
    int s;
    clear_mon();
    @(posedge clk);
    #1;
    s = cyc;
    rx = 1'b0;
    hold(100);
    rx = 1'b1;
    wait_cyc(s + 216);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b want 1", busy); end
    wait_cyc(s + 224);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b want 0", busy); end
    hold(300);
    checks++; if (dv_cnt != 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", dv_cnt); end
    checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL glitch_frame_err: got %0d want 0", ferr_cnt); end
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL glitch_overrun: got %0d want 0", ovr_cnt); end
  endtask

  task automatic test_overrun();
    logic [7:0] b1 = 8'h01;
    logic [7:0] b2 = 8'h02;
    int s1, s2;
    clear_mon();
    data_ready = 1'b0;
    send_frame(b1, even_bit(b1), 1'b1, s1);
    send_frame(b2, even_bit(b2), 1'b1, s2);
    hold(100);
    @(negedge clk);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL ovr_held_valid: got %b want 1", data_valid); end
    checks++; if (data_out !== b1) begin errors++; $display("FAIL ovr_held_data: got %h want %h", data_out, b1); end
    checks++; if (ovr_cnt != 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt); end
    checks++;
    if (ovr_cyc < s2 + LAT - 2 || ovr_cyc > s2 + LAT + 2) begin
      errors++; $display("FAIL ovr_timing: got cycle %0d want %0d", ovr_cyc, s2 + LAT);
    end
    @(posedge clk);
    #1;
    data_ready = 1'b1;
    hold(5);
    @(negedge clk);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ovr_transfers: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0][7:0] !== b1) begin errors++; $display("FAIL ovr_transfer_data: got %h want %h", got_q[0][7:0], b1); end
    end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_clear: got %b want 0", data_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b = 8'h53;
    int s;
    clear_mon();
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    rx = 1'b0;
    hold(BT);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      hold(BT);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data_out: got %h want 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", data_valid); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rstmid_perr: got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_ferr: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b want 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx = 1'b1;
    hold(600);
    clear_mon();
    send_frame(b, even_bit(b), 1'b1, s);
    hold(100);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== {1'b0, b}) begin errors++; $display("FAIL rstmid_word: got %h want %h", got_q[0], {1'b0, b}); end
    end
    checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL rstmid_frame_err: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q[$];
    logic [7:0] b;
    logic       bad;
    int s;
    clear_mon();
    data_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      exp_q.push_back({bad, b});
      send_frame(b, even_bit(b) ^ bad, 1'b1, s);
    end
    hold(100);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
      checks++;
      if (got_q[n] !== exp_q[n]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", n, got_q[n], exp_q[n]); end
    end
    checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL b2b_frame_err: got %0d want 0", ferr_cnt); end
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL b2b_overrun: got %0d want 0", ovr_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    data_ready = 1'b1;
    clear_mon();
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", checks, errors);
    $finish;
  end

endmodule
